// File: rtl/sha256_block_feeder.sv
// SHA-256 block feeder: buffers message words into 512-bit blocks, applies
// padding and the 64-bit length, streams blocks to the core and captures the digest.
module sha256_block_feeder (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [31:0]  in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_last,
    input  logic [1:0]   in_bytes,
    input  logic         core_ready,
    input  logic         core_busy,
    output logic [31:0]  core_word,
    output logic         core_word_valid,
    output logic         core_first_block,
    output logic         core_last_block,
    input  logic         core_output_enable,
    input  logic [31:0]  core_digest_word,
    output logic [255:0] digest,
    output logic         digest_valid
);

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned BLK_WORDS = 16;
    localparam int unsigned IDX_W     = 5;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned CNT_W     = 64;
    localparam int unsigned DIG_WORDS = 8;
    localparam int unsigned DIG_W     = DIG_WORDS * WORD_W;
    localparam int unsigned CAP_W     = 3;
    localparam int unsigned BITS_W    = 6;

    localparam logic [IDX_W-1:0]  IDX_LEN_HI = IDX_W'(14);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(15);
    localparam logic [IDX_W-1:0]  IDX_FULL   = IDX_W'(16);
    localparam logic [CAP_W-1:0]  CAP_LAST   = CAP_W'(DIG_WORDS - 1);
    localparam logic [WORD_W-1:0] PAD_WORD   = 32'h8000_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_PAD,
        S_LEN,
        S_SEND,
        S_WAIT_DIG
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CAP_W-1:0]   cap_q, cap_d;
    logic               msg_done_q, msg_done_d;
    logic               pad80_q, pad80_d;
    logic               first_blk_q, first_blk_d;
    logic               final_blk_q, final_blk_d;

    logic               in_ready_q, in_ready_d;
    logic [WORD_W-1:0]  core_word_q, core_word_d;
    logic               core_word_valid_q, core_word_valid_d;
    logic               core_first_q, core_first_d;
    logic               core_last_q, core_last_d;
    logic [DIG_W-1:0]   digest_q, digest_d;
    logic               digest_valid_q, digest_valid_d;

    logic [WORD_W-1:0]  blk_mem [BLK_WORDS];
    logic               buf_we;
    logic [ADDR_W-1:0]  buf_waddr;
    logic [WORD_W-1:0]  buf_wdata;

    logic [WORD_W-1:0]  last_word;
    logic [BITS_W-1:0]  last_bits;
    logic               accept;

    assign accept = in_valid && in_ready_q;

    // Final word: keep the valid bytes, terminate with 0x80 and zeros
    always_comb begin
        last_word = in_data;
        last_bits = BITS_W'(32);
        case (in_bytes)
            2'd1: begin
                last_word = {in_data[31:24], 24'h80_0000};
                last_bits = BITS_W'(8);
            end
            2'd2: begin
                last_word = {in_data[31:16], 16'h8000};
                last_bits = BITS_W'(16);
            end
            2'd3: begin
                last_word = {in_data[31:8], 8'h80};
                last_bits = BITS_W'(24);
            end
            default: begin
                last_word = in_data;
                last_bits = BITS_W'(32);
            end
        endcase
    end

    // Next-state and output logic
    always_comb begin
        state_d           = state_q;
        idx_d             = idx_q;
        bit_cnt_d         = bit_cnt_q;
        cap_d             = cap_q;
        msg_done_d        = msg_done_q;
        pad80_d           = pad80_q;
        first_blk_d       = first_blk_q;
        final_blk_d       = final_blk_q;
        core_word_d       = core_word_q;
        core_word_valid_d = 1'b0;
        core_first_d      = 1'b0;
        core_last_d       = 1'b0;
        digest_d          = digest_q;
        digest_valid_d    = 1'b0;
        buf_we            = 1'b0;
        buf_waddr         = idx_q[ADDR_W-1:0];
        buf_wdata         = in_data;

        case (state_q)
            S_IDLE: begin
                if (!core_busy) begin
                    state_d     = S_FILL;
                    idx_d       = '0;
                    bit_cnt_d   = '0;
                    msg_done_d  = 1'b0;
                    pad80_d     = 1'b0;
                    first_blk_d = 1'b1;
                    final_blk_d = 1'b0;
                end
            end
            S_FILL: begin
                if (accept) begin
                    buf_we = 1'b1;
                    idx_d  = idx_q + IDX_W'(1);
                    if (in_last) begin
                        buf_wdata  = last_word;
                        bit_cnt_d  = bit_cnt_q + CNT_W'(last_bits);
                        msg_done_d = 1'b1;
                        pad80_d    = (in_bytes == 2'd0);
                        state_d    = S_PAD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(32);
                        if (idx_q == IDX_LAST) begin
                            state_d = S_SEND;
                            idx_d   = '0;
                        end
                    end
                end
            end
            S_PAD: begin
                // A pending 0x80 word is placed before any length decision
                if (idx_q == IDX_FULL) begin
                    state_d = S_SEND;
                    idx_d   = '0;
                end else if (idx_q == IDX_LEN_HI && !pad80_q) begin
                    state_d = S_LEN;
                end else begin
                    buf_we    = 1'b1;
                    buf_wdata = pad80_q ? PAD_WORD : '0;
                    pad80_d   = 1'b0;
                    idx_d     = idx_q + IDX_W'(1);
                end
            end
            S_LEN: begin
                buf_we = 1'b1;
                idx_d  = idx_q + IDX_W'(1);
                if (idx_q == IDX_LEN_HI) begin
                    buf_wdata = bit_cnt_q[63:32];
                end else begin
                    buf_wdata   = bit_cnt_q[31:0];
                    final_blk_d = 1'b1;
                    state_d     = S_SEND;
                    idx_d       = '0;
                end
            end
            S_SEND: begin
                // core_ready only gates the start; the block then streams back-to-back
                if (idx_q != '0 || core_ready) begin
                    core_word_d       = blk_mem[idx_q[ADDR_W-1:0]];
                    core_word_valid_d = 1'b1;
                    core_first_d      = (idx_q == '0) && first_blk_q;
                    core_last_d       = (idx_q == '0) && final_blk_q;
                    idx_d             = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
                        idx_d       = '0;
                        first_blk_d = 1'b0;
                        if (final_blk_q) begin
                            state_d = S_WAIT_DIG;
                            cap_d   = '0;
                        end else if (msg_done_q) begin
                            state_d = S_PAD;
                        end else begin
                            state_d = S_FILL;
                        end
                    end
                end
            end
            S_WAIT_DIG: begin
                if (core_output_enable) begin
                    for (int unsigned i = 0; i < DIG_WORDS; i++) begin
                        if (cap_q == CAP_W'(i)) begin
                            digest_d[(DIG_WORDS-1-i)*WORD_W +: WORD_W] = core_digest_word;
                        end
                    end
                    cap_d = cap_q + CAP_W'(1);
                    if (cap_q == CAP_LAST) begin
                        digest_valid_d = 1'b1;
                        cap_d          = '0;
                        state_d        = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_FILL) && (idx_d < IDX_FULL);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q           <= S_IDLE;
            idx_q             <= '0;
            bit_cnt_q         <= '0;
            cap_q             <= '0;
            msg_done_q        <= 1'b0;
            pad80_q           <= 1'b0;
            first_blk_q       <= 1'b0;
            final_blk_q       <= 1'b0;
            in_ready_q        <= 1'b0;
            core_word_q       <= '0;
            core_word_valid_q <= 1'b0;
            core_first_q      <= 1'b0;
            core_last_q       <= 1'b0;
            digest_q          <= '0;
            digest_valid_q    <= 1'b0;
        end else begin
            state_q           <= state_d;
            idx_q             <= idx_d;
            bit_cnt_q         <= bit_cnt_d;
            cap_q             <= cap_d;
            msg_done_q        <= msg_done_d;
            pad80_q           <= pad80_d;
            first_blk_q       <= first_blk_d;
            final_blk_q       <= final_blk_d;
            in_ready_q        <= in_ready_d;
            core_word_q       <= core_word_d;
            core_word_valid_q <= core_word_valid_d;
            core_first_q      <= core_first_d;
            core_last_q       <= core_last_d;
            digest_q          <= digest_d;
            digest_valid_q    <= digest_valid_d;
        end
    end

    // Block buffer, no reset needed
    always_ff @(posedge clk) begin
        if (buf_we) begin
            blk_mem[buf_waddr] <= buf_wdata;
        end
    end

    assign in_ready         = in_ready_q;
    assign core_word        = core_word_q;
    assign core_word_valid  = core_word_valid_q;
    assign core_first_block = core_first_q;
    assign core_last_block  = core_last_q;
    assign digest           = digest_q;
    assign digest_valid     = digest_valid_q;

endmodule

// File: doc/sha256_block_feeder.md
SHA256_BLOCK_FEEDER -- requirements
Module: sha256_block_feeder

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  synchronous reset, active-low.
- in_data  in  32  message word, big-endian; first byte in [31:24].
- in_valid  in  1  in_data valid.
- in_ready  out  1  feeder accepts in_data this cycle.
- in_last  in  1  final message word.
- in_bytes  in  2  valid bytes in the final word; 0 means 4. Ignored unless in_last.
- core_ready  in  1  hash core can take a block.
- core_busy  in  1  hash core is processing a message.
- core_word  out  32  block word to the core.
- core_word_valid  out  1  core_word valid.
- core_first_block  out  1  marks the first block of a message.
- core_last_block  out  1  marks the last block of a message.
- core_output_enable  in  1  digest window from the core.
- core_digest_word  in  32  digest word from the core, H0 first.
- digest  out  256  captured digest, H0 in [255:224].
- digest_valid  out  1  digest holds the result of the last message.

Function
REQ-002 The FSM SHALL have states IDLE, FILL, PAD, LEN, SEND, WAIT_DIG.
REQ-003 IDLE -> FILL when core_busy=0. in_ready=0 in IDLE.
REQ-004 FILL: in_ready=1 while word index < 16. Each accepted word is written to a 16x32 block buffer at the index, and the index increments.
REQ-005 FILL: the bit counter (64-bit, wraps at 2^64) SHALL add 32 per word, or 8*in_bytes (32 when in_bytes=0) on the in_last word.
REQ-006 FILL: when index reaches 16 and in_last has not yet been seen, the FSM SHALL go to SEND.
REQ-007 On an in_last word:
- Bytes after the valid bytes SHALL be replaced with 0x80 followed by zeros.
- If in_bytes=0, a new word 0x80000000 SHALL be appended at the next index (via PAD).
- The FSM SHALL then go to PAD.
REQ-008 PAD SHALL zero-fill words, one per cycle, until index=14, then go to LEN.
REQ-009 If the 0x80 word lands at index 14 or 15, PAD SHALL zero-fill to 16 and go to SEND. An extra block, all zeros except the length, SHALL follow.
REQ-010 If the message is a multiple of 64 bytes, the extra block SHALL be 0x80000000, zeros, then the length.
REQ-011 LEN SHALL write bit_count[63:32] at index 14 and bit_count[31:0] at index 15 over 2 cycles, then go to SEND.
REQ-012 SEND SHALL wait for core_ready=1, then drive buffer words 0..15 on 16 consecutive cycles with core_word_valid=1.
REQ-013 core_first_block=1 only on send cycle 0 of a message's first block.
REQ-014 core_last_block=1 only on send cycle 0 of the final (length-bearing) block. Both SHALL assert together for a single-block message.
REQ-015 After SEND the FSM SHALL go to FILL (more message data), PAD (extra block pending), or WAIT_DIG (final block sent). The index resets to 0.
REQ-016 WAIT_DIG SHALL capture core_digest_word on the first 8 cycles with core_output_enable=1, then pulse digest_valid for 1 cycle and return to IDLE.
REQ-017 digest SHALL hold its value until the next capture.
REQ-018 in_ready SHALL be 0 in PAD, LEN, SEND and WAIT_DIG. in_valid in those states SHALL be ignored.
REQ-019 An in_last word accepted at index 15 SHALL be treated as REQ-009.

Reset
REQ-020 While reset_n=0 at a clk edge:
- state=IDLE; index, bit counter and capture count = 0.
- in_ready, core_word_valid, core_first_block, core_last_block, digest_valid = 0.
- core_word=0, digest=0.
REQ-021 Reset mid-SEND or mid-capture SHALL abort immediately with no further core_word_valid. Buffer contents need not be cleared.

Verification
REQ-022 "abc" (in_data=0x61626300, in_last=1, in_bytes=3) -> one block: word0=0x61626380, words1-14=0, word15=0x00000018. first and last both 1 on cycle 0. With the core model: digest=ba7816bf...f20015ad, digest_valid pulses once.
REQ-023 14 full words, last with in_bytes=0 -> two blocks: block 1 words14/15 = 0x80000000/0; block 2 words0-13=0, word15=0x000001C0. Only block 2 has core_last_block.
REQ-024 16 full words -> block 2 = 0x80000000, zeros, word15=0x00000200.
REQ-025 core_ready held 0 for 10 cycles in SEND -> no core_word_valid until core_ready=1, then exactly 16 contiguous valid cycles.
REQ-026 reset_n=0 on send cycle 7 -> next cycle all outputs at reset values; a following "abc" run produces the correct digest.
REQ-027 in_valid toggled randomly during FILL -> block contents identical to a gap-free run.
